// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: request/response bus between the fetch stage and instruction memory
interface if_fetch_stage_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  modport master(output imem_req_valid, imem_req_addr, input imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave(input imem_req_valid, imem_req_addr, output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC generation, pipelined imem fetch with stale-response drop, IF/ID register
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PC_en,
  input  logic             if_id_en,
  input  logic             take_branch,
  input  logic [31:0]      target_pc,
  if_fetch_stage_if.master imem,
  output logic [31:0]      if_id_IR,
  output logic [31:0]      if_id_PC,
  output logic             if_id_valid_inst
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   fetch_pc;
  logic [CW-1:0] live_cnt, drop_cnt, fifo_cnt;
  logic [31:0]   req_pc [DEPTH];
  logic [31:0]   fifo_pc [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [AW-1:0] q_wr, q_rd, f_wr, f_rd;
  logic          acc, rsp_any, keep, pop;
  // live+fifo bounded by DEPTH keeps both the PC queue and the FIFO from overflowing
  assign imem.imem_req_valid = rst & PC_en & ~take_branch & (drop_cnt == '0) &
                               (({1'b0, live_cnt} + {1'b0, fifo_cnt}) < (CW+1)'(DEPTH));
  assign imem.imem_req_addr  = fetch_pc;
  assign acc     = imem.imem_req_valid & imem.imem_req_ready;
  assign rsp_any = imem.imem_rsp_valid & ((drop_cnt != '0) | (live_cnt != '0));
  assign keep    = rsp_any & (drop_cnt == '0);
  assign pop     = if_id_en & (fifo_cnt != '0);
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc         <= RESET_PC;
      live_cnt         <= '0;
      drop_cnt         <= '0;
      fifo_cnt         <= '0;
      q_wr             <= '0;
      q_rd             <= '0;
      f_wr             <= '0;
      f_rd             <= '0;
      if_id_IR         <= NOP_INST;
      if_id_PC         <= '0;
      if_id_valid_inst <= 1'b0;
    end else if (take_branch) begin
      fetch_pc         <= target_pc;
      drop_cnt         <= drop_cnt + live_cnt - CW'(rsp_any);
      live_cnt         <= '0;
      fifo_cnt         <= '0;
      q_wr             <= '0;
      q_rd             <= '0;
      f_wr             <= '0;
      f_rd             <= '0;
      if_id_IR         <= NOP_INST;
      if_id_valid_inst <= 1'b0;
    end else begin
      if (acc) begin
        req_pc[q_wr] <= fetch_pc;
        q_wr         <= q_wr + 1'b1;
        fetch_pc     <= fetch_pc + 32'd4;
      end
      if (keep) begin
        fifo_pc[f_wr]   <= req_pc[q_rd];
        fifo_inst[f_wr] <= imem.imem_rsp_data;
        f_wr            <= f_wr + 1'b1;
        q_rd            <= q_rd + 1'b1;
      end
      live_cnt <= live_cnt + CW'(acc) - CW'(keep);
      drop_cnt <= drop_cnt - CW'(rsp_any & ~keep);
      fifo_cnt <= fifo_cnt + CW'(keep) - CW'(pop);
      if (if_id_en) begin
        if_id_IR         <= pop ? fifo_inst[f_rd] : NOP_INST;
        if_id_valid_inst <= pop;
        if (pop) begin
          if_id_PC <= fifo_pc[f_rd];
          f_rd     <= f_rd + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: queue-based reference model plus directed and random fetch scenarios
module tb_if_fetch_stage;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  logic clk, rst, PC_en, if_id_en, take_branch;
  logic [31:0] target_pc, if_id_IR, if_id_PC;
  logic if_id_valid_inst;
  if_fetch_stage_if imem();
  if_fetch_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .PC_en(PC_en), .if_id_en(if_id_en), .take_branch(take_branch),
    .target_pc(target_pc), .imem(imem), .if_id_IR(if_id_IR), .if_id_PC(if_id_PC),
    .if_id_valid_inst(if_id_valid_inst));
  initial clk = 0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  function automatic void cmp(string n, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endfunction
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h3C5A_0F13;
  endfunction
  // reference model: queues of live request PCs and buffered {pc,inst}
  typedef struct {int due; logic [31:0] addr;} mreq_t;
  mreq_t mq[$];
  logic [31:0] lq[$], fpc[$], fin[$];
  logic [31:0] m_pc = 0, m_ir = NOP, m_ipc = 0, last_pc = 0, nd = 0;
  logic m_v = 0, m_new = 0, have_last = 0, nv = 0, e_rv, acc, started = 0, rand_lat = 0;
  int md = 0, cyc = 0, last_due = 0, L = 1, due;
  always @(negedge clk) begin
    e_rv = rst && PC_en && !take_branch && md == 0 && (lq.size() + fpc.size() < DEPTH);
    if (started) begin
      cmp("req_valid", imem.imem_req_valid, e_rv);
      cmp("req_addr", imem.imem_req_addr, m_pc);
      cmp("if_id_IR", if_id_IR, m_ir);
      cmp("if_id_PC", if_id_PC, m_ipc);
      cmp("if_id_valid", if_id_valid_inst, m_v);
      if (m_new && if_id_valid_inst) begin
        cmp("inst_word", if_id_IR, mem_word(if_id_PC));
        if (have_last) cmp("pc_step", if_id_PC, last_pc + 32'd4);
        last_pc = m_ipc;
        have_last = 1;
      end
    end
    acc = e_rv && imem.imem_req_ready;
    m_new = 0;
    if (!rst) begin
      m_pc = 0; md = 0; m_ir = NOP; m_ipc = 0; m_v = 0; have_last = 0;
      lq.delete(); fpc.delete(); fin.delete(); mq.delete();
      last_due = cyc;
    end else if (take_branch) begin
      md = md + lq.size() - ((imem.imem_rsp_valid && (md != 0 || lq.size() != 0)) ? 1 : 0);
      lq.delete(); fpc.delete(); fin.delete();
      m_pc = target_pc; m_ir = NOP; m_v = 0; have_last = 0;
    end else begin
      if (if_id_en) begin
        if (fpc.size() > 0) begin
          m_ipc = fpc.pop_front(); m_ir = fin.pop_front(); m_v = 1; m_new = 1;
        end else begin
          m_ir = NOP; m_v = 0;
        end
      end
      if (imem.imem_rsp_valid) begin
        if (md > 0) md--;
        else if (lq.size() > 0) begin
          fpc.push_back(lq.pop_front());
          fin.push_back(imem.imem_rsp_data);
        end
      end
      if (acc) begin lq.push_back(m_pc); m_pc += 4; end
    end
    // memory: in-order responses, one per cycle at most, latency >= L
    if (rst && imem.imem_req_valid && imem.imem_req_ready) begin
      due = cyc + (rand_lat ? int'($urandom_range(1, 5)) : L);
      if (due <= last_due) due = last_due + 1;
      mq.push_back('{due, imem.imem_req_addr});
      last_due = due;
    end
    cyc++;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      nv = 1; nd = mem_word(mq[0].addr); void'(mq.pop_front());
    end else nv = 0;
  end
  always @(posedge clk) begin
    #1;
    imem.imem_rsp_valid = nv;
    imem.imem_rsp_data  = nd;
  end
  task automatic step(); @(posedge clk); #1; endtask
  task automatic at_neg(); @(negedge clk); endtask
  initial begin
    rst = 0; PC_en = 1; if_id_en = 1; take_branch = 0; target_pc = 0;
    imem.imem_req_ready = 1;
    step(); started = 1; step();
    at_neg();
    cmp("rst_IR", if_id_IR, NOP);
    cmp("rst_PC", if_id_PC, 32'h0);
    cmp("rst_valid", if_id_valid_inst, 0);
    cmp("rst_req_valid", imem.imem_req_valid, 0);
    step();
    rst = 1;
    for (int k = 0; k < 12; k++) begin
      if_id_en = !(k >= 6 && k <= 8);
      at_neg();
      if (k == 0) cmp("t1_first_req", imem.imem_req_valid, 1);
      if (k < 2) cmp("t1_req_addr", imem.imem_req_addr, 32'(4 * k));
      if (k >= 3 && k <= 5) begin
        cmp("t1_pc", if_id_PC, 32'(4 * (k - 3)));
        cmp("t1_valid", if_id_valid_inst, 1);
      end
      if (k == 8 || k == 9) cmp("stall_req_blocked", imem.imem_req_valid, 0);
      if (k >= 6 && k <= 9) cmp("stall_hold_pc", if_id_PC, 32'd12);
      if (k == 10) cmp("stall_release_pc", if_id_PC, 32'd16);
      if (k == 11) cmp("stall_next_pc", if_id_PC, 32'd20);
      step();
    end
    PC_en = 0;
    repeat (10) step();
    L = 3; PC_en = 1;
    for (int j = 0; j < 14; j++) begin
      take_branch = (j == 3 || j == 12);
      target_pc = (j == 3) ? 32'h100 : 32'h200;
      if_id_en = (j != 12);
      if (j == 4) cmp("model_drop_cnt", 32'(md), 32'd2);
      at_neg();
      if (j == 4) cmp("br_flush_valid", if_id_valid_inst, 0);
      if (j == 4 || j == 5) cmp("br_drop_block", imem.imem_req_valid, 0);
      if (j == 6) begin
        cmp("br_refetch_valid", imem.imem_req_valid, 1);
        cmp("br_refetch_addr", imem.imem_req_addr, 32'h100);
      end
      if (j == 11) begin
        cmp("br_target_pc", if_id_PC, 32'h100);
        cmp("br_target_valid", if_id_valid_inst, 1);
        cmp("br_target_ir", if_id_IR, mem_word(32'h100));
      end
      if (j == 12) cmp("br_second_pc", if_id_PC, 32'h104);
      if (j == 13) begin
        cmp("br_stall_flush_ir", if_id_IR, NOP);
        cmp("br_stall_flush_valid", if_id_valid_inst, 0);
        cmp("br_stall_hold_pc", if_id_PC, 32'h104);
      end
      step();
    end
    take_branch = 0; if_id_en = 1; rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      PC_en = ($urandom_range(0, 4) != 0);
      if_id_en = ($urandom_range(0, 4) != 0);
      take_branch = ($urandom_range(0, 19) == 0);
      target_pc = 32'($urandom_range(0, 1023)) << 2;
      imem.imem_req_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    PC_en = 0; if_id_en = 1; take_branch = 0; imem.imem_req_ready = 1; rand_lat = 0; L = 1;
    repeat (15) step();
    for (int j = 0; j < 8; j++) begin
      PC_en = 1;
      L = (j < 3) ? 4 : 1;
      rst = (j != 3);
      at_neg();
      if (j == 3) cmp("mid_rst_req_valid", imem.imem_req_valid, 0);
      if (j == 4) begin
        cmp("mid_rst_IR", if_id_IR, NOP);
        cmp("mid_rst_PC", if_id_PC, 32'h0);
        cmp("mid_rst_valid", if_id_valid_inst, 0);
        cmp("mid_rst_req_valid1", imem.imem_req_valid, 1);
        cmp("mid_rst_req_addr", imem.imem_req_addr, 32'h0);
      end
      if (j == 7) begin
        cmp("restart_pc", if_id_PC, 32'h0);
        cmp("restart_valid", if_id_valid_inst, 1);
        cmp("restart_ir", if_id_IR, mem_word(32'h0));
      end
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
